// File: rtl/alexander_pd_voter_pkg.sv
// Shared types and helpers for the Alexander phase detector voter.
// Used by alexander_pd_voter and pd_word_counter via import pd_pkg::*.
package pd_pkg;

    typedef enum logic [1:0] {PD_NONE, PD_EARLY, PD_LATE, PD_INVALID} pd_class_e;

    // Classify one A-T-B triplet: A earlier data bit, T edge sample, B later data bit.
    function automatic pd_class_e pd_classify(input logic a, input logic t, input logic b);
        if (a == b) begin
            return (t == a) ? PD_NONE : PD_INVALID;
        end
        return (t == a) ? PD_EARLY : PD_LATE;
    endfunction

    // Signed accumulator width that holds +/- (window * data_w) without overflow.
    function automatic int pd_acc_width(input int window, input int data_w);
        return $clog2(window * data_w + 1) + 1;
    endfunction

endpackage

// File: rtl/alexander_pd_voter_if.sv
// Sampler-side / loop-filter-side signal bundle of the phase detector voter.
interface alexander_pd_voter_if #(
    parameter int DATA_W = 10
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] edge_in;
    logic              freeze;
    logic              Up;
    logic              Dn;
    logic [15:0]       err_cnt;

    modport master (
        output valid_in, data_in, edge_in, freeze,
        input  Up, Dn, err_cnt
    );

    modport slave (
        input  valid_in, data_in, edge_in, freeze,
        output Up, Dn, err_cnt
    );
endinterface

// File: rtl/alexander_pd_voter_word_counter.sv
// Combinational per-word triplet classification and popcounts.
// Slot 0 is the boundary crossing from the previous word (skipped until
// history is valid); slots 1..DATA_W-1 are the boundaries inside the word.
module pd_word_counter
    import pd_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] edge_in,
    input  logic              hist_data,
    input  logic              hist_edge,
    input  logic              hist_vld,
    output logic [CNT_W-1:0]  late_cnt,
    output logic [CNT_W-1:0]  early_cnt,
    output logic [CNT_W-1:0]  inv_cnt
);

    pd_class_e cls [DATA_W];

    // Classify every bit boundary of the word, including the cross-word one.
    always_comb begin
        cls[0] = hist_vld ? pd_classify(hist_data, hist_edge, data_in[0]) : PD_NONE;
        for (int i = 1; i < DATA_W; i++) begin
            cls[i] = pd_classify(data_in[i-1], edge_in[i-1], data_in[i]);
        end
    end

    // Popcount the late, early and invalid classifications.
    always_comb begin
        late_cnt  = '0;
        early_cnt = '0;
        inv_cnt   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (cls[i] == PD_LATE)    late_cnt  = late_cnt  + CNT_W'(1);
            if (cls[i] == PD_EARLY)   early_cnt = early_cnt + CNT_W'(1);
            if (cls[i] == PD_INVALID) inv_cnt   = inv_cnt   + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alexander_pd_voter.sv
// Bang-bang (Alexander) phase detector with windowed majority vote.
// Up = sampling clock late (advance), Dn = sampling clock early (retard).
// Optional macro PD_VOTE_STATS_EN compiles in the saturating invalid-pattern
// counter on err_cnt; without it err_cnt is tied to zero.
module alexander_pd_voter
    import pd_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int WINDOW = 8,
    parameter int THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alexander_pd_voter_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int ACC_W = pd_acc_width(WINDOW, DATA_W);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic signed [ACC_W-1:0] THR_POS  = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG  = -THR_POS;
    localparam logic        [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    // Net vote of one word: late minus early, widened to the accumulator.
    function automatic logic signed [ACC_W-1:0] vote_delta(input logic [CNT_W-1:0] late,
                                                           input logic [CNT_W-1:0] early);
        logic signed [ACC_W-1:0] l;
        logic signed [ACC_W-1:0] e;
        l = ACC_W'(late);
        e = ACC_W'(early);
        return l - e;
    endfunction

    logic              wrd_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] edge_p0;
    logic              hist_data;
    logic              hist_edge;
    logic              hist_vld;
    logic [CNT_W-1:0]  late_cnt;
    logic [CNT_W-1:0]  early_cnt;
    logic [CNT_W-1:0]  inv_cnt;
    logic              vld_p1;
    logic [CNT_W-1:0]  late_p1;
    logic [CNT_W-1:0]  early_p1;
    logic signed [ACC_W-1:0] acc_p2;
    logic signed [ACC_W-1:0] acc_next;
    logic [WIN_W-1:0]  win_cnt_p2;
    logic              up_p2;
    logic              dn_p2;

    // ---- stage 0: input word capture ----
    // Capture the word payload; qualified downstream by the valid flags.
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            data_p0 <= bus.data_in;
            edge_p0 <= bus.edge_in;
        end
    end

    // wrd_p0 marks any word (history/stats); vld_p0 marks a word that may vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrd_p0 <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            wrd_p0 <= bus.valid_in;
            vld_p0 <= bus.valid_in & ~bus.freeze;
        end
    end

    // History validity: set by the first word after reset, never by freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld <= 1'b0;
        end else if (wrd_p0) begin
            hist_vld <= 1'b1;
        end
    end

    // Last data/edge bit of the previous word for the cross-word boundary.
    always_ff @(posedge clk) begin
        if (wrd_p0) begin
            hist_data <= data_p0[DATA_W-1];
            hist_edge <= edge_p0[DATA_W-1];
        end
    end

    pd_word_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_word_counter (
        .data_in   (data_p0),
        .edge_in   (edge_p0),
        .hist_data (hist_data),
        .hist_edge (hist_edge),
        .hist_vld  (hist_vld),
        .late_cnt  (late_cnt),
        .early_cnt (early_cnt),
        .inv_cnt   (inv_cnt)
    );

    // ---- stage 1: per-word vote counts ----
    // Register the late/early popcounts of a voting word.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            late_p1  <= late_cnt;
            early_p1 <= early_cnt;
        end
    end

    // Stage-1 valid; freeze kills the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 & ~bus.freeze;
        end
    end

    // ---- stage 2: window accumulation and pulse decision ----
    assign acc_next = acc_p2 + vote_delta(late_p1, early_p1);

    // Accumulate the window; on its last word decide the pulse and restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2     <= '0;
            win_cnt_p2 <= '0;
            up_p2      <= 1'b0;
            dn_p2      <= 1'b0;
        end else begin
            up_p2 <= 1'b0;
            dn_p2 <= 1'b0;
            if (bus.freeze) begin
                acc_p2     <= '0;
                win_cnt_p2 <= '0;
            end else if (vld_p1) begin
                if (win_cnt_p2 == WIN_LAST) begin
                    acc_p2     <= '0;
                    win_cnt_p2 <= '0;
                    up_p2      <= (acc_next >= THR_POS);
                    dn_p2      <= (acc_next <= THR_NEG);
                end else begin
                    acc_p2     <= acc_next;
                    win_cnt_p2 <= win_cnt_p2 + WIN_W'(1);
                end
            end
        end
    end

    assign bus.Up = up_p2;
    assign bus.Dn = dn_p2;

`ifdef PD_VOTE_STATS_EN
    // Add an invalid count to the error counter, sticking at all-ones.
    function automatic logic [15:0] err_sat_add(input logic [15:0] cnt, input logic [CNT_W-1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic             wrd_p1;
    logic [CNT_W-1:0] inv_p1;
    logic [15:0]      err_cnt_p2;

    // Register the invalid count of every word, frozen or not.
    always_ff @(posedge clk) begin
        if (wrd_p0) begin
            inv_p1 <= inv_cnt;
        end
    end

    // Word flag for the stats path; freeze does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrd_p1 <= 1'b0;
        end else begin
            wrd_p1 <= wrd_p0;
        end
    end

    // Saturating invalid-pattern counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_p2 <= '0;
        end else if (wrd_p1) begin
            err_cnt_p2 <= err_sat_add(err_cnt_p2, inv_p1);
        end
    end

    assign bus.err_cnt = err_cnt_p2;
`else
    logic unused_inv;
    assign unused_inv  = ^inv_cnt;
    assign bus.err_cnt = 16'h0000;
`endif

endmodule
